digest_reader: RTL and testbench
================================

# digest_reader

Digest reader: the receiving end of the 16-bit word output link driven by the SHA3-512 core's output converter. It is the link master. It toggles the request line (the converter's GPIO17 input) once per word and samples the 16-bit data bus after a settle delay. It assembles 32 words into the 512-bit digest and optionally compares it against an expected value. It sits on the test/loopback side of the core, in the same clock domain as the converter.

## Interface
Parameters:
- `WORD_W`, 16, link data width
- `WORDS`, 32, words per digest (`WORD_W*WORDS` = 512)
- `SETTLE`, 4, cycles each request phase is held before the next action; legal range 1..255

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low; `reset`=0 at a `clk` edge resets the block
- `go`  in  1  start pulse; sampled only in IDLE
- `kill`  in  1  abort; level-sensitive, any state
- `data_in`  in  16  word bus from the converter (the core's `GPIOout`)
- `expected`  in  512  reference digest for comparison; must be stable while `digest_valid`=1
- `req`  out  1  request/strobe to the converter (drives `GPIO17`)
- `digest`  out  512  assembled digest; the first word received is in [511:496]
- `digest_valid`  out  1  high from DONE until the next accepted `go`, `kill` or reset
- `match`  out  1  `digest == expected`; valid only when `digest_valid`=1, otherwise 0
- `busy`  out  1  high in REQ_HI and REQ_LO
- `word_idx`  out  5  index of the word currently being fetched, 0..31

## Operation
- States: IDLE, REQ_HI, REQ_LO, DONE.
- Reset values: all outputs 0, state IDLE, settle counter 0.
- IDLE:
  - on `go`=1 and `kill`=0: clear `digest`, `digest_valid` and `match`; set `word_idx`=0; go to REQ_HI.
- REQ_HI:
  - `req`=1; the settle counter counts 0..`SETTLE`-1.
  - On the last count, shift in: `digest <= {digest[495:0], data_in}`.
  - Then go to REQ_LO.
- REQ_LO:
  - `req`=0; count `SETTLE` cycles.
  - On the last count, if `word_idx`==31 go to DONE; otherwise increment `word_idx` and go to REQ_HI.
- DONE:
  - set `digest_valid`=1 and register `match` from `digest == expected`.
  - Go to IDLE, holding `digest_valid` and `match`.
- Word order: MSB word first, so the converter's `raw512[511:496]` is received first.
- `kill`=1 in any state:
  - next state IDLE; `req`=0; `digest`, `digest_valid`, `match` and `word_idx` cleared.
  - `kill` has priority over `go` and over the word-complete transition in the same cycle.
  - While `kill` stays high, `go` is ignored.
- `go` outside IDLE is ignored; no queuing.
- A reset mid-transfer forces reset values immediately; the partial digest is discarded.
- The 512-bit compare is combinational into a register; one compare per digest.

## Timing
- The `go` cycle (IDLE) is cycle 0; `req` rises in cycle 1.
- Per word: `req` is high for exactly `SETTLE` cycles, then low for exactly `SETTLE` cycles.
- `data_in` is sampled on the last cycle of the high phase, `SETTLE`-1 cycles after the `req` rising edge. The converter must present the word within that window.
- `req` has no glitches; it is a registered output.
- `digest_valid` and `match` rise together, `1 + 2*SETTLE*32 + 1` cycles after `go`. That is 258 cycles at `SETTLE`=4.
- `busy` falls in the same cycle that the state enters DONE.

## Structure
- Shared package `sha3_pkg`:
  - `DIGEST_W`=512 and `LINK_W`=16 constants;
  - `reader_state_t` enum: IDLE, REQ_HI, REQ_LO, DONE.
- Sub-module `settle_timer`:
  - 8-bit down-counter with load and `expire` outputs;
  - shared by both request phases.
- Top level: FSM, 512-bit shift register, word counter, compare register.

## Test plan
- Model converter presents words 0x0001..0x0020 on successive `req` rises; `expected` = that concatenation, `SETTLE`=4 -> `digest[511:496]`=0x0001, `digest[15:0]`=0x0020, `match`=1, `digest_valid` at cycle 258, exactly 32 `req` pulses.
- Same stimulus with `expected[0]` flipped -> `digest_valid`=1, `match`=0.
- `kill` asserted during word 10 of a transfer -> next cycle `req`=0, `busy`=0, `digest`=0, `word_idx`=0; a new `go` gives a full correct digest.
- `go` pulsed during REQ_LO of word 5, and again with `kill` in the same IDLE cycle -> both ignored; `req` pulse count unchanged.
- `reset`=0 for one cycle during word 20 -> all outputs 0 on the next cycle; `SETTLE`=1 rerun -> `digest_valid` at cycle 66, digest correct.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3-512 test-side link blocks.
package sha3_pkg;

    localparam int unsigned DIGEST_W = 512;
    localparam int unsigned LINK_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        DONE   = 2'd3
    } reader_state_t;

endpackage

// File: rtl/settle_timer.sv
// 8-bit down-counter that times one request phase; expire is high while the count is zero.
module settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/digest_reader.sv
// Link master for the converter's 16-bit word output: strobes req once per word, assembles
// the digest MSB word first and registers a compare against the expected value.
module digest_reader
    import sha3_pkg::*;
#(
    parameter int unsigned WORD_W = LINK_W,
    parameter int unsigned WORDS  = DIGEST_W / LINK_W,
    parameter int unsigned SETTLE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     kill,
    input  logic [WORD_W-1:0]        data_in,
    input  logic [WORD_W*WORDS-1:0]  expected,
    output logic                     req,
    output logic [WORD_W*WORDS-1:0]  digest,
    output logic                     digest_valid,
    output logic                     match,
    output logic                     busy,
    output logic [4:0]               word_idx
);

    localparam int unsigned DW          = WORD_W * WORDS;
    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [4:0]  LAST_IDX    = 5'(WORDS - 1);

    reader_state_t state_q;
    logic          timer_load;
    logic [7:0]    timer_val;
    logic          timer_expire;

    settle_timer u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    // Each phase reloads the timer as it is entered, so it expires on the phase's last cycle.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = SETTLE_LOAD;
        if (kill) begin
            timer_load = 1'b1;
            timer_val  = '0;
        end else begin
            unique case (state_q)
                IDLE:           timer_load = go;
                REQ_HI, REQ_LO: timer_load = timer_expire;
                default:        timer_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            req          <= 1'b0;
            busy         <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            match        <= 1'b0;
            word_idx     <= '0;
        end else if (kill) begin
            state_q      <= IDLE;
            req          <= 1'b0;
            busy         <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            match        <= 1'b0;
            word_idx     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        digest       <= '0;
                        digest_valid <= 1'b0;
                        match        <= 1'b0;
                        word_idx     <= '0;
                        req          <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (timer_expire) begin
                        digest  <= {digest[DW-WORD_W-1:0], data_in};
                        req     <= 1'b0;
                        state_q <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (timer_expire) begin
                        if (word_idx == LAST_IDX) begin
                            busy    <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            word_idx <= word_idx + 5'd1;
                            req      <= 1'b1;
                            state_q  <= REQ_HI;
                        end
                    end
                end
                DONE: begin
                    digest_valid <= 1'b1;
                    match        <= (digest == expected);
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_reader.sv
// Bench for digest_reader: two instances (SETTLE=4 and SETTLE=1) checked every cycle
// against a cycle-arithmetic model, plus literal expectations for the directed runs.
module tb_digest_reader;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         go[2];
    logic         kill[2];
    logic [15:0]  data_in[2];
    logic [511:0] expected[2];
    logic         req_w[2];
    logic [511:0] digest_w[2];
    logic         dv_w[2];
    logic         match_w[2];
    logic         busy_w[2];
    logic [4:0]   widx_w[2];

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    // Converter model state
    logic [15:0] tab[2][32];
    bit          req_seen[2];
    int          cnt[2];
    int          pulses[2];

    // Reference model state: e = cycles since the accepted go (0 = not transferring)
    int           e[2];
    logic [511:0] m_dig[2];
    logic         m_val[2];
    logic         m_mat[2];
    logic [4:0]   m_idx[2];

    always #5 clk = ~clk;

    digest_reader #(.WORD_W(16), .WORDS(32), .SETTLE(S0)) dut0 (
        .clk(clk), .reset(reset), .go(go[0]), .kill(kill[0]), .data_in(data_in[0]),
        .expected(expected[0]), .req(req_w[0]), .digest(digest_w[0]),
        .digest_valid(dv_w[0]), .match(match_w[0]), .busy(busy_w[0]), .word_idx(widx_w[0])
    );

    digest_reader #(.WORD_W(16), .WORDS(32), .SETTLE(S1)) dut1 (
        .clk(clk), .reset(reset), .go(go[1]), .kill(kill[1]), .data_in(data_in[1]),
        .expected(expected[1]), .req(req_w[1]), .digest(digest_w[1]),
        .digest_valid(dv_w[1]), .match(match_w[1]), .busy(busy_w[1]), .word_idx(widx_w[1])
    );

    function automatic int settle_of(int i);
        return (i == 0) ? S0 : S1;
    endfunction

    task automatic chk(string name, int inst, logic [511:0] act, logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, inst, act, exp);
        end
    endtask

    // Converter: new word on each req rise, garbage once req falls.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (go[i] === 1'b1 && e[i] == 0) cnt[i] = 0;
            if (req_w[i] === 1'b1 && !req_seen[i]) begin
                data_in[i] = tab[i][cnt[i] % 32];
                cnt[i]++;
                pulses[i]++;
            end else if (req_w[i] === 1'b0 && req_seen[i]) begin
                data_in[i] = 16'($urandom);
            end
            req_seen[i] = (req_w[i] === 1'b1);
        end
    end

    always @(posedge clk) begin
        int s, n;
        for (int i = 0; i < 2; i++) begin
            s = settle_of(i);
            n = 2 * s * 32;
            if (!reset || kill[i]) begin
                e[i] = 0; m_dig[i] = '0; m_val[i] = 1'b0; m_mat[i] = 1'b0; m_idx[i] = '0;
            end else if (e[i] == 0) begin
                if (go[i]) begin
                    e[i] = 1; m_dig[i] = '0; m_val[i] = 1'b0; m_mat[i] = 1'b0; m_idx[i] = '0;
                end
            end else begin
                if (e[i] <= n && (e[i] - 1) % (2 * s) == s - 1)
                    m_dig[i] = {m_dig[i][495:0], data_in[i]};
                if (e[i] == n + 1) begin
                    m_val[i] = 1'b1;
                    m_mat[i] = (m_dig[i] == expected[i]);
                    e[i] = 0;
                end else begin
                    e[i]++;
                end
                if (e[i] >= 1 && e[i] <= n) m_idx[i] = 5'((e[i] - 1) / (2 * s));
            end
        end
    end

    always @(negedge clk) begin
        int s, n;
        bit er, eb;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                s  = settle_of(i);
                n  = 2 * s * 32;
                eb = (e[i] >= 1 && e[i] <= n);
                er = eb && (((e[i] - 1) % (2 * s)) < s);
                chk("req", i, 512'(req_w[i]), 512'(er));
                chk("busy", i, 512'(busy_w[i]), 512'(eb));
                chk("word_idx", i, 512'(widx_w[i]), 512'(m_idx[i]));
                chk("digest", i, digest_w[i], m_dig[i]);
                chk("digest_valid", i, 512'(dv_w[i]), 512'(m_val[i]));
                chk("match", i, 512'(match_w[i]), 512'(m_mat[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tab(int i, bit seq);
        for (int w = 0; w < 32; w++) tab[i][w] = seq ? 16'(w + 1) : 16'($urandom);
    endtask

    function automatic logic [511:0] tab_cat(int i);
        logic [511:0] r = '0;
        for (int w = 0; w < 32; w++) r = {r[495:0], tab[i][w]};
        return r;
    endfunction

    task automatic start(int i);
        go[i] = 1'b1;
        tick();
        go[i] = 1'b0;
    endtask

    // Returns the cycle (go cycle = 0) in which digest_valid is first seen high.
    task automatic wait_valid(int i, output int cyc);
        cyc = 1;
        while (!dv_w[i] && cyc < 2000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_word(int i, int w, string name);
        int c = 0;
        while (widx_w[i] != 5'(w) && c < 2000) begin
            tick();
            c++;
        end
        chk(name, i, 512'(widx_w[i]), 512'(w));
    endtask

    task automatic check_all_zero(int i, string tag);
        chk({tag, "_req"}, i, 512'(req_w[i]), 512'(0));
        chk({tag, "_busy"}, i, 512'(busy_w[i]), 512'(0));
        chk({tag, "_digest"}, i, digest_w[i], 512'(0));
        chk({tag, "_valid"}, i, 512'(dv_w[i]), 512'(0));
        chk({tag, "_match"}, i, 512'(match_w[i]), 512'(0));
        chk({tag, "_word_idx"}, i, 512'(widx_w[i]), 512'(0));
    endtask

    initial begin
        int cyc, p0, killed;
        logic [511:0] one;
        one = 512'd1;
        for (int i = 0; i < 2; i++) begin
            go[i] = 1'b0; kill[i] = 1'b0; data_in[i] = '0; expected[i] = '0;
            req_seen[i] = 1'b0; cnt[i] = 0; pulses[i] = 0;
            e[i] = 0; m_dig[i] = '0; m_val[i] = 1'b0; m_mat[i] = 1'b0; m_idx[i] = '0;
            load_tab(i, 1'b1);
        end

        reset = 1'b0;
        tick();
        armed = 1'b1;
        tick();
        check_all_zero(0, "reset");
        reset = 1'b1;
        tick();

        // Sequential words 0x0001..0x0020, matching expected value
        load_tab(0, 1'b1);
        expected[0] = tab_cat(0);
        p0 = pulses[0];
        start(0);
        wait_valid(0, cyc);
        chk("valid_cycle", 0, 512'(cyc), 512'(258));
        chk("req_pulses", 0, 512'(pulses[0] - p0), 512'(32));
        chk("first_word", 0, 512'(digest_w[0][511:496]), 512'(16'h0001));
        chk("last_word", 0, 512'(digest_w[0][15:0]), 512'(16'h0020));
        chk("match_hit", 0, 512'(match_w[0]), 512'(1));

        // Same words, expected bit 0 flipped
        expected[0] = tab_cat(0) ^ one;
        start(0);
        wait_valid(0, cyc);
        chk("miss_valid", 0, 512'(dv_w[0]), 512'(1));
        chk("match_miss", 0, 512'(match_w[0]), 512'(0));

        // Kill during word 10, then a clean rerun
        expected[0] = tab_cat(0);
        start(0);
        wait_word(0, 10, "reach_word10");
        kill[0] = 1'b1;
        tick();
        kill[0] = 1'b0;
        check_all_zero(0, "kill");
        tick();
        p0 = pulses[0];
        start(0);
        wait_valid(0, cyc);
        chk("rerun_cycle", 0, 512'(cyc), 512'(258));
        chk("rerun_digest", 0, digest_w[0], tab_cat(0));
        chk("rerun_match", 0, 512'(match_w[0]), 512'(1));
        chk("rerun_pulses", 0, 512'(pulses[0] - p0), 512'(32));

        // Stray go during REQ_LO of word 5 is ignored
        p0 = pulses[0];
        start(0);
        cyc = 1;
        begin
            bit injected = 1'b0;
            while (!dv_w[0] && cyc < 2000) begin
                if (!injected && widx_w[0] == 5'd5 && !req_w[0]) begin
                    go[0] = 1'b1;
                    injected = 1'b1;
                end
                tick();
                go[0] = 1'b0;
                cyc++;
            end
            chk("stray_go_seen", 0, 512'(injected), 512'(1));
        end
        chk("stray_go_cycle", 0, 512'(cyc), 512'(258));
        chk("stray_go_pulses", 0, 512'(pulses[0] - p0), 512'(32));

        // go together with kill in IDLE: kill wins, nothing starts
        go[0] = 1'b1;
        kill[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        kill[0] = 1'b0;
        check_all_zero(0, "go_kill");
        p0 = pulses[0];
        repeat (20) tick();
        chk("go_kill_pulses", 0, 512'(pulses[0] - p0), 512'(0));

        // Reset during word 20
        start(0);
        wait_word(0, 20, "reach_word20");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all_zero(0, "midreset");
        tick();

        // SETTLE=1 instance
        load_tab(1, 1'b1);
        expected[1] = tab_cat(1);
        p0 = pulses[1];
        start(1);
        wait_valid(1, cyc);
        chk("s1_valid_cycle", 1, 512'(cyc), 512'(66));
        chk("s1_digest", 1, digest_w[1], tab_cat(1));
        chk("s1_match", 1, 512'(match_w[1]), 512'(1));
        chk("s1_pulses", 1, 512'(pulses[1] - p0), 512'(32));

        // Randomized runs: random words, random hit/miss, occasional kill and stray go
        for (int r = 0; r < 12; r++) begin
            int i;
            i = r % 2;
            load_tab(i, 1'b0);
            expected[i] = tab_cat(i) ^ (($urandom_range(1) == 1) ? (one << $urandom_range(511))
                                                                   : 512'd0);
            start(i);
            killed = 0;
            for (int c = 0; c < 2000 && !dv_w[i]; c++) begin
                if ($urandom_range(299) == 0) begin
                    kill[i] = 1'b1;
                    tick();
                    kill[i] = 1'b0;
                    killed = 1;
                    break;
                end
                go[i] = ($urandom_range(24) == 0);
                tick();
                go[i] = 1'b0;
            end
            chk("rand_done", i, 512'(dv_w[i] | (killed != 0)), 512'(1));
            repeat ($urandom_range(3)) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
